// File: rtl/chan_scan_pkg.sv
// Shared encodings for the channel scan multiplexer: FSM states and request modes.
package chan_scan_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_scan_mux_nto1.sv
// Combinational N:1 word selector from a flat bus; indices with no channel behind them return 0.
module mux_nto1 #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 32,
   parameter int SEL_W  = $clog2(N_CH)
) (
   input  logic [N_CH*DATA_W-1:0] i_dat,
   input  logic [SEL_W-1:0]       i_sel,
   output logic [DATA_W-1:0]      o_dat
);

   always_comb begin
      o_dat = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (i_sel == SEL_W'(k)) o_dat = i_dat[k*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/chan_scan_mux.sv
// Selects one channel or scans a channel range, presenting each word with its index on a
// registered valid/ready output; first word is valid 1 cycle after start, stalls hold data stable.
module chan_scan_mux
   import chan_scan_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N_CH   = 32,
   parameter int SEL_W  = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_CH*DATA_W-1:0] d_in,
   input  logic                   start,
   input  logic                   mode,
   input  logic [SEL_W-1:0]       sel_first,
   input  logic [SEL_W-1:0]       sel_last,
   input  logic                   abort,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [SEL_W-1:0]       out_chan,
   output logic                   out_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   // One extra bit so N_CH == 2^SEL_W is representable as the exclusive limit.
   localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_CH);

   state_t              r_state;
   logic [DATA_W-1:0]   r_data;
   logic [SEL_W-1:0]    r_chan;
   logic [SEL_W-1:0]    r_last;
   logic                r_valid;
   logic                r_done;
   logic                r_err;

   state_t              w_nxt_state;
   logic [DATA_W-1:0]   w_nxt_data;
   logic [SEL_W-1:0]    w_nxt_chan;
   logic [SEL_W-1:0]    w_nxt_last;
   logic                w_nxt_valid;
   logic                w_nxt_done;
   logic                w_nxt_err;

   logic [SEL_W-1:0]    w_mux_sel;
   logic [DATA_W-1:0]   w_mux_dat;
   logic [SEL_W-1:0]    w_chan_inc;
   logic                w_legal;

   assign w_chan_inc = r_chan + SEL_W'(1);
   assign w_mux_sel  = (r_state == ST_IDLE) ? sel_first : w_chan_inc;

   assign w_legal = ({1'b0, sel_first} < N_LIM) &&
                    ((mode == MODE_SINGLE) ||
                     (({1'b0, sel_last} < N_LIM) && (sel_first <= sel_last)));

   mux_nto1 #(
      .DATA_W (DATA_W),
      .N_CH   (N_CH),
      .SEL_W  (SEL_W)
   ) u_mux (
      .i_dat  (d_in),
      .i_sel  (w_mux_sel),
      .o_dat  (w_mux_dat)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_data  = r_data;
      w_nxt_chan  = r_chan;
      w_nxt_last  = r_last;
      w_nxt_valid = r_valid;
      w_nxt_done  = 1'b0;
      w_nxt_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               if (w_legal) begin
                  w_nxt_data  = w_mux_dat;
                  w_nxt_chan  = sel_first;
                  w_nxt_last  = (mode == MODE_SCAN) ? sel_last : sel_first;
                  w_nxt_valid = 1'b1;
                  w_nxt_state = ST_EMIT;
               end else begin
                  w_nxt_err   = 1'b1;
               end
            end
         end
         ST_EMIT: begin
            // Abort wins over a same-cycle handshake: the word is gone but no done.
            if (abort) begin
               w_nxt_valid = 1'b0;
               w_nxt_state = ST_IDLE;
            end else if (r_valid && out_ready) begin
               if (r_chan == r_last) begin
                  w_nxt_valid = 1'b0;
                  w_nxt_done  = 1'b1;
                  w_nxt_state = ST_IDLE;
               end else begin
                  w_nxt_chan  = w_chan_inc;
                  w_nxt_data  = w_mux_dat;
               end
            end
         end
         default: begin
            w_nxt_valid = 1'b0;
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_chan  <= '0;
         r_last  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_data  <= w_nxt_data;
         r_chan  <= w_nxt_chan;
         r_last  <= w_nxt_last;
         r_valid <= w_nxt_valid;
         r_done  <= w_nxt_done;
         r_err   <= w_nxt_err;
      end
   end

   assign out_data  = r_data;
   assign out_chan  = r_chan;
   assign out_valid = r_valid;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: a 32-channel instance driven from a vector table plus
// hand sequences, and a 20-channel instance for the non-power-of-two legality corners.
module tb_chan_scan_mux;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // 32-channel instance
   logic [32*8-1:0] a_d_in;
   logic            a_start, a_mode, a_abort, a_ready;
   logic [4:0]      a_first, a_last;
   logic [7:0]      a_data;
   logic [4:0]      a_chan;
   logic            a_valid, a_busy, a_done, a_err;

   chan_scan_mux dut_a (
      .clk       (clk),
      .reset_n   (reset_n),
      .d_in      (a_d_in),
      .start     (a_start),
      .mode      (a_mode),
      .sel_first (a_first),
      .sel_last  (a_last),
      .abort     (a_abort),
      .out_ready (a_ready),
      .out_data  (a_data),
      .out_chan  (a_chan),
      .out_valid (a_valid),
      .busy      (a_busy),
      .done      (a_done),
      .err       (a_err)
   );

   // 20-channel instance
   logic [20*8-1:0] b_d_in;
   logic            b_start, b_mode, b_abort, b_ready;
   logic [4:0]      b_first, b_last;
   logic [7:0]      b_data;
   logic [4:0]      b_chan;
   logic            b_valid, b_busy, b_done, b_err;

   chan_scan_mux #(.DATA_W(8), .N_CH(20)) dut_b (
      .clk       (clk),
      .reset_n   (reset_n),
      .d_in      (b_d_in),
      .start     (b_start),
      .mode      (b_mode),
      .sel_first (b_first),
      .sel_last  (b_last),
      .abort     (b_abort),
      .out_ready (b_ready),
      .out_data  (b_data),
      .out_chan  (b_chan),
      .out_valid (b_valid),
      .busy      (b_busy),
      .done      (b_done),
      .err       (b_err)
   );

   typedef struct {
      logic        start;
      logic        mode;
      logic [4:0]  first;
      logic [4:0]  last;
      logic        abort;
      logic        ready;
      logic [16:0] exp;    // {valid, data, chan, busy, done, err}
   } vec_t;

   vec_t tv[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [16:0] obs_a();
      return {a_valid, a_data, a_chan, a_busy, a_done, a_err};
   endfunction

   function automatic logic [16:0] obs_b();
      return {b_valid, b_data, b_chan, b_busy, b_done, b_err};
   endfunction

   function automatic logic [16:0] pk(input logic v, input int d, input int c,
                                      input logic b, input logic dn, input logic e);
      return {v, 8'(d), 5'(c), b, dn, e};
   endfunction

   task automatic add(input logic s, input logic m, input int f, input int l,
                      input logic ab, input logic rd, input logic [16:0] e);
      vec_t v;
      v.start = s; v.mode = m; v.first = 5'(f); v.last = 5'(l);
      v.abort = ab; v.ready = rd; v.exp = e;
      tv.push_back(v);
   endtask

   task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {v,data,chan,busy,done,err}=%h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic s, input logic m, input int f, input int l,
                          input logic ab, input logic rd);
      a_start = s; a_mode = m; a_first = 5'(f); a_last = 5'(l); a_abort = ab; a_ready = rd;
   endtask

   task automatic drive_b(input logic s, input logic m, input int f, input int l);
      b_start = s; b_mode = m; b_first = 5'(f); b_last = 5'(l);
   endtask

   task automatic fill_a();
      for (int k = 0; k < 32; k++) a_d_in[k*8 +: 8] = 8'(8'hA0 + k);
   endtask

   initial begin
      reset_n = 1'b0;
      fill_a();
      for (int k = 0; k < 20; k++) b_d_in[k*8 +: 8] = 8'(8'hA0 + k);
      drive_a(0, 0, 0, 0, 0, 1);
      drive_b(0, 0, 0, 0);
      b_abort = 1'b0;
      b_ready = 1'b1;
      #1;
      check("reset_a", obs_a(), pk(0, 0, 0, 0, 0, 0));
      check("reset_b", obs_b(), pk(0, 0, 0, 0, 0, 0));
      step();
      step();
      reset_n = 1'b1;

      //  start mode first last abort ready -> {valid, data, chan, busy, done, err}
      add(0, 0,  0,  0, 0, 1, pk(0, 8'h00,  0, 0, 0, 0));
      add(1, 0,  5,  9, 0, 1, pk(1, 8'hA5,  5, 1, 0, 0));
      add(0, 0,  0,  0, 0, 1, pk(0, 8'hA5,  5, 0, 1, 0));
      add(0, 0,  0,  0, 0, 1, pk(0, 8'hA5,  5, 0, 0, 0));
      add(1, 1,  3,  6, 0, 1, pk(1, 8'hA3,  3, 1, 0, 0));
      add(0, 0,  0,  0, 0, 1, pk(1, 8'hA4,  4, 1, 0, 0));
      add(0, 0,  0,  0, 0, 1, pk(1, 8'hA5,  5, 1, 0, 0));
      add(0, 0,  0,  0, 0, 1, pk(1, 8'hA6,  6, 1, 0, 0));
      add(0, 0,  0,  0, 0, 1, pk(0, 8'hA6,  6, 0, 1, 0));
      add(1, 1,  7,  4, 0, 1, pk(0, 8'hA6,  6, 0, 0, 1));
      add(0, 0,  0,  0, 0, 1, pk(0, 8'hA6,  6, 0, 0, 0));
      add(1, 1,  2,  2, 0, 0, pk(1, 8'hA2,  2, 1, 0, 0));
      add(0, 0,  0,  0, 0, 0, pk(1, 8'hA2,  2, 1, 0, 0));
      add(0, 0,  0,  0, 0, 1, pk(0, 8'hA2,  2, 0, 1, 0));
      add(1, 0, 31,  0, 0, 1, pk(1, 8'hBF, 31, 1, 0, 0));
      add(0, 0,  0,  0, 0, 1, pk(0, 8'hBF, 31, 0, 1, 0));
      add(1, 0,  4,  4, 1, 1, pk(0, 8'hBF, 31, 0, 0, 0));

      for (int i = 0; i < tv.size(); i++) begin
         drive_a(tv[i].start, tv[i].mode, int'(tv[i].first), int'(tv[i].last),
                 tv[i].abort, tv[i].ready);
         step();
         check($sformatf("vec%0d", i), obs_a(), tv[i].exp);
      end

      // Stall: held word ignores d_in changes; next word is taken from live d_in.
      drive_a(1, 1, 0, 2, 0, 0);
      step();
      check("stall_load", obs_a(), pk(1, 8'hA0, 0, 1, 0, 0));
      drive_a(0, 0, 0, 0, 0, 0);
      a_d_in[0*8 +: 8] = 8'h55;
      step();
      check("stall_hold", obs_a(), pk(1, 8'hA0, 0, 1, 0, 0));
      a_d_in[1*8 +: 8] = 8'h77;
      a_ready = 1'b1;
      step();
      check("stall_live", obs_a(), pk(1, 8'h77, 1, 1, 0, 0));
      a_ready = 1'b0;
      step();
      check("stall_hold2", obs_a(), pk(1, 8'h77, 1, 1, 0, 0));
      a_ready = 1'b1;
      step();
      check("stall_last", obs_a(), pk(1, 8'hA2, 2, 1, 0, 0));
      step();
      check("stall_done", obs_a(), pk(0, 8'hA2, 2, 0, 1, 0));
      fill_a();

      // Abort after the third word; a start during the scan is ignored.
      drive_a(1, 1, 0, 31, 0, 1);
      step();
      check("abort_w1", obs_a(), pk(1, 8'hA0, 0, 1, 0, 0));
      drive_a(1, 0, 9, 9, 0, 1);
      step();
      check("abort_busy_start", obs_a(), pk(1, 8'hA1, 1, 1, 0, 0));
      drive_a(0, 0, 0, 0, 0, 1);
      step();
      check("abort_w3", obs_a(), pk(1, 8'hA2, 2, 1, 0, 0));
      a_abort = 1'b1;
      step();
      check("abort_hit", obs_a(), pk(0, 8'hA2, 2, 0, 0, 0));
      a_abort = 1'b0;
      step();
      check("abort_nodone", obs_a(), pk(0, 8'hA2, 2, 0, 0, 0));

      // Asynchronous reset mid-scan, then a fresh single request.
      drive_a(1, 1, 10, 20, 0, 1);
      step();
      drive_a(0, 0, 0, 0, 0, 1);
      step();
      check("rst_pre", obs_a(), pk(1, 8'hAB, 11, 1, 0, 0));
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async", obs_a(), pk(0, 0, 0, 0, 0, 0));
      step();
      reset_n = 1'b1;
      step();
      check("rst_nodone", obs_a(), pk(0, 0, 0, 0, 0, 0));
      drive_a(1, 0, 31, 3, 0, 1);
      step();
      check("rst_single31", obs_a(), pk(1, 8'hBF, 31, 1, 0, 0));
      drive_a(0, 0, 0, 0, 0, 1);
      step();
      check("rst_single31_done", obs_a(), pk(0, 8'hBF, 31, 0, 1, 0));

      // 20-channel build: out-of-range and inverted ranges are rejected.
      drive_b(1, 0, 25, 0);
      step();
      check("n20_single25", obs_b(), pk(0, 0, 0, 0, 0, 1));
      drive_b(0, 0, 0, 0);
      step();
      check("n20_err_clr", obs_b(), pk(0, 0, 0, 0, 0, 0));
      drive_b(1, 1, 7, 4);
      step();
      check("n20_scan7_4", obs_b(), pk(0, 0, 0, 0, 0, 1));
      drive_b(1, 1, 3, 20);
      step();
      check("n20_scan_last20", obs_b(), pk(0, 0, 0, 0, 0, 1));
      drive_b(1, 1, 19, 19);
      step();
      check("n20_scan19", obs_b(), pk(1, 8'hB3, 19, 1, 0, 0));
      drive_b(0, 0, 0, 0);
      step();
      check("n20_scan19_done", obs_b(), pk(0, 8'hB3, 19, 0, 1, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
